instr_fetch_unit: RTL

- Parametrised instruction fetch stage: PC register, synchronous instruction memory, 2-entry output buffer, valid/ready handshake to decode.
- Supports branch/jump redirect with flush, run/stop control, and a program-load port active while stopped.
- Sits between the program loader and the decode stage.
- Memory contents are never cleared by reset.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/instr_mem.sv | 32 +++
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// FSM state encodings and the halt opcode used when IFU_HALT_DETECT_EN is set.
package ifu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;

    // Fetch control states. These are plain constants rather than an enum so
    // older code that compares raw 2-bit state values keeps working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Top six instruction bits that mark a halt word.
    localparam logic [5:0] HALT_OPCODE = 6'b011111;

endpackage

// File: rtl/instr_mem.sv
// Synchronous 1R1W instruction RAM. The read data is registered, so a word
// appears one cycle after its read is issued. Contents are never cleared.
module instr_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, updated only when a fetch is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, registered instruction RAM, 2-entry output
// FIFO with valid/ready towards decode, redirect/flush, run/stop control and
// a program-load port that only writes while IDLE.
// Optional build macro: IFU_HALT_DETECT_EN enables halt-opcode detection;
// without it the opcode is ignored and halted is tied low.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              halted
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [1:0]        count_reg;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] slot_instr [2];
    logic [ADDR_W-1:0] slot_pc    [2];

    logic       pop, push, flush, issue, mem_we;
    logic [2:0] occupancy;
    logic [1:0] wr_slot;
    logic       halt_block, halt_pop, halt_hold;

    assign pop       = out_valid & out_ready;
    // Words held or on their way once this cycle's pop has left.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign flush     = redirect_valid & ((state_reg != ST_IDLE) | halt_hold);
    assign push      = inflight_reg & ~flush;
    assign issue     = (state_reg == ST_FETCH) & ~flush & (occupancy < 3'd2) & ~halt_block;
    assign wr_slot   = count_reg - {1'b0, pop};
    assign mem_we    = prog_we & (state_reg == ST_IDLE) & ~rst;

    assign out_valid = (count_reg != 2'd0);
    assign out_instr = slot_instr[0];
    assign out_pc    = slot_pc[0];
    assign busy      = (state_reg != ST_IDLE);

    instr_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (issue),
        .raddr (pc_reg),
        .rdata (rd_data)
    );

`ifdef IFU_HALT_DETECT_EN
    logic halt_pending_reg, halted_reg, halt_hit;

    // A halt word arriving from the RAM stops any further issue, so no
    // younger word can follow it into the buffer.
    assign halt_hit   = push & (rd_data[DATA_W-1 -: 6] == HALT_OPCODE);
    // Nothing is pushed after the halt word, so it is the last entry left.
    assign halt_pop   = halt_pending_reg & pop & (count_reg == 2'd1);
    assign halt_block = halt_pending_reg | halt_hit;
    assign halt_hold  = halted_reg;
    assign halted     = halted_reg;

    // Track a buffered halt word and latch halted once decode takes it.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            halt_pending_reg <= 1'b0;
            halted_reg       <= 1'b0;
        end else if (halt_pop) begin
            halt_pending_reg <= 1'b0;
            halted_reg       <= 1'b1;
        end else if (halt_hit) begin
            halt_pending_reg <= 1'b1;
        end
    end
`else
    assign halt_block = 1'b0;
    assign halt_pop   = 1'b0;
    assign halt_hold  = 1'b0;
    assign halted     = 1'b0;
`endif

    // Run/stop sequencing; a retired halt word forces IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (run && !halt_hold) state_next = ST_FETCH;
            ST_FETCH: if (!run) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (run) begin
                    state_next = ST_FETCH;
                end else if (!inflight_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
        if (halt_pop) begin
            state_next = ST_IDLE;
        end
    end

    // State, PC and in-flight tracking; a redirect wins over issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            if (flush) begin
                pc_reg <= redirect_pc;
            end else if (issue) begin
                pc_reg          <= pc_reg + 1'b1;
                inflight_pc_reg <= pc_reg;
            end
        end
    end

    // Buffer occupancy; a flush drops everything including the in-flight word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Two buffer slots; slot 0 is the head. On a pop slot 0 takes slot 1, and
    // slot 1 picking up the old head is harmless because it is then empty.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [DATA_W-1:0] instr_reg;
        logic [ADDR_W-1:0] pc_slot_reg;

        // Load this slot on a push aimed at it, otherwise shift on pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                instr_reg   <= '0;
                pc_slot_reg <= '0;
            end else if (push && (wr_slot == 2'(gi))) begin
                instr_reg   <= rd_data;
                pc_slot_reg <= inflight_pc_reg;
            end else if (pop) begin
                instr_reg   <= slot_instr[(gi + 1) % 2];
                pc_slot_reg <= slot_pc[(gi + 1) % 2];
            end
        end

        assign slot_instr[gi] = instr_reg;
        assign slot_pc[gi]    = pc_slot_reg;
    end

endmodule
